// File: rtl/expr_pkg.sv
// Shared lexer/parser definitions: token kinds, ASCII codes and default literal width.
// Consumed by expr_tokenizer and the downstream infix-to-postfix stage.
package expr_pkg;

   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      TOK_NUM = 2'd0,
      TOK_OP  = 2'd1,
      TOK_END = 2'd2
   } tok_kind_e;

   localparam logic [7:0] CH_PLUS  = 8'h2B;
   localparam logic [7:0] CH_MINUS = 8'h2D;
   localparam logic [7:0] CH_STAR  = 8'h2A;
   localparam logic [7:0] CH_SLASH = 8'h2F;
   localparam logic [7:0] CH_LPAR  = 8'h28;
   localparam logic [7:0] CH_RPAR  = 8'h29;
   localparam logic [7:0] CH_SPACE = 8'h20;

   function automatic logic is_digit(input logic [7:0] c);
      return (c >= 8'h30) && (c <= 8'h39);
   endfunction

endpackage

// File: rtl/expr_tokenizer_dec_accum.sv
// Combinational decimal accumulate step: acc*10 + d, saturating to all-ones
// with an overflow flag when the exact result does not fit in DATA_W bits.
module dec_accum #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] acc_i,
   input  logic [3:0]        digit_i,
   output logic [DATA_W-1:0] sum_o,
   output logic              ovf_o
);

   logic [DATA_W+3:0] wide_acc;
   logic [DATA_W+3:0] prod;

   // (2^W-1)*10+9 < 2^(W+4), so four guard bits hold the exact result
   assign wide_acc = {4'b0000, acc_i};
   assign prod     = (wide_acc << 3) + (wide_acc << 1) + {{DATA_W{1'b0}}, digit_i};
   assign ovf_o    = |prod[DATA_W+3:DATA_W];
   assign sum_o    = ovf_o ? {DATA_W{1'b1}} : prod[DATA_W-1:0];

endmodule

// File: rtl/expr_tokenizer.sv
// Byte-serial expression lexer emitting NUM/OP/END tokens with error flags on END.
// Define EXPR_TOKENIZER_PAREN_EN to accept '(' and ')' as operator bytes.
module expr_tokenizer
   import expr_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        in_char,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [1:0]        out_kind,
   output logic [7:0]        out_op,
   output logic [DATA_W-1:0] out_value,
   output logic              err_overflow,
   output logic              err_char
);

   typedef enum logic [1:0] {S_IDLE, S_NUM, S_FLUSH, S_FINAL} state_e;

   function automatic logic is_op(input logic [7:0] c);
`ifdef EXPR_TOKENIZER_PAREN_EN
      return c inside {CH_PLUS, CH_MINUS, CH_STAR, CH_SLASH, CH_LPAR, CH_RPAR};
`else
      return c inside {CH_PLUS, CH_MINUS, CH_STAR, CH_SLASH};
`endif
   endfunction

   state_e            state_q, state_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [7:0]        op_q, op_d;
   logic              last_q, last_d;
   logic              ovf_q, ovf_d;
   logic              chr_q, chr_d;
   logic              out_valid_q, out_valid_d;
   tok_kind_e         out_kind_q, out_kind_d;
   logic [7:0]        out_op_q, out_op_d;
   logic [DATA_W-1:0] out_value_q, out_value_d;

   logic [DATA_W-1:0] acc_sum;
   logic              acc_ovf;
   logic              slot_free;
   logic              accept;

   dec_accum #(.DATA_W(DATA_W)) u_dec_accum (
      .acc_i   (acc_q),
      .digit_i (in_char[3:0]),
      .sum_o   (acc_sum),
      .ovf_o   (acc_ovf)
   );

   assign slot_free = !out_valid_q || out_ready;
   assign in_ready  = ((state_q == S_IDLE) || (state_q == S_NUM)) && slot_free;
   assign accept    = in_valid && in_ready;

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      op_d        = op_q;
      last_d      = last_q;
      ovf_d       = ovf_q;
      chr_d       = chr_q;
      out_valid_d = out_valid_q && !out_ready;
      out_kind_d  = out_kind_q;
      out_op_d    = out_op_q;
      out_value_d = out_value_q;

      case (state_q)
         S_IDLE, S_NUM: begin
            if (accept) begin
               if (is_digit(in_char)) begin
                  acc_d   = acc_sum;
                  ovf_d   = ovf_q || acc_ovf;
                  state_d = S_NUM;
                  if (in_last) begin
                     out_valid_d = 1'b1;
                     out_kind_d  = TOK_NUM;
                     out_op_d    = 8'h00;
                     out_value_d = acc_sum;
                     acc_d       = '0;
                     state_d     = S_FINAL;
                  end
               end else if (is_op(in_char)) begin
                  out_valid_d = 1'b1;
                  if (state_q == S_NUM) begin
                     // number goes out now, the operator waits one token slot
                     out_kind_d  = TOK_NUM;
                     out_op_d    = 8'h00;
                     out_value_d = acc_q;
                     acc_d       = '0;
                     op_d        = in_char;
                     last_d      = in_last;
                     state_d     = S_FLUSH;
                  end else begin
                     out_kind_d  = TOK_OP;
                     out_op_d    = in_char;
                     out_value_d = '0;
                     state_d     = in_last ? S_FINAL : S_IDLE;
                  end
               end else begin
                  if (in_char != CH_SPACE) begin
                     chr_d = 1'b1;
                  end
                  // a space always terminates a literal; an illegal byte only does so when last
                  if ((state_q == S_NUM) && ((in_char == CH_SPACE) || in_last)) begin
                     out_valid_d = 1'b1;
                     out_kind_d  = TOK_NUM;
                     out_op_d    = 8'h00;
                     out_value_d = acc_q;
                     acc_d       = '0;
                     state_d     = S_IDLE;
                  end
                  if (in_last) begin
                     state_d = S_FINAL;
                  end
               end
            end
         end
         S_FLUSH: begin
            if (slot_free) begin
               out_valid_d = 1'b1;
               out_kind_d  = TOK_OP;
               out_op_d    = op_q;
               out_value_d = '0;
               last_d      = 1'b0;
               state_d     = last_q ? S_FINAL : S_IDLE;
            end
         end
         default: begin
            if (out_valid_q && (out_kind_q == TOK_END)) begin
               if (out_ready) begin
                  state_d = S_IDLE;
                  acc_d   = '0;
                  ovf_d   = 1'b0;
                  chr_d   = 1'b0;
               end
            end else if (slot_free) begin
               out_valid_d = 1'b1;
               out_kind_d  = TOK_END;
               out_op_d    = 8'h00;
               out_value_d = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         acc_q       <= '0;
         op_q        <= 8'h00;
         last_q      <= 1'b0;
         ovf_q       <= 1'b0;
         chr_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_kind_q  <= TOK_NUM;
         out_op_q    <= 8'h00;
         out_value_q <= '0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         op_q        <= op_d;
         last_q      <= last_d;
         ovf_q       <= ovf_d;
         chr_q       <= chr_d;
         out_valid_q <= out_valid_d;
         out_kind_q  <= out_kind_d;
         out_op_q    <= out_op_d;
         out_value_q <= out_value_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign out_kind     = out_kind_q;
   assign out_op       = out_op_q;
   assign out_value    = out_value_q;
   assign err_overflow = ovf_q;
   assign err_char     = chr_q;

endmodule

// File: tb/tb_expr_tokenizer.sv
// Directed scoreboard bench for expr_tokenizer: expected tokens are queued as
// each expression is driven and checked as the DUT hands them downstream.
module tb_expr_tokenizer;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_char;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  out_kind;
   logic [7:0]  out_op;
   logic [31:0] out_value;
   logic        err_overflow;
   logic        err_char;

   typedef struct {
      logic [1:0]  kind;
      logic [7:0]  op;
      logic [31:0] value;
      logic        eo;
      logic        ec;
   } tok_t;

   tok_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   logic        stall_mode = 1'b0;
   int          hold_cnt   = 0;
   logic [1:0]  cap_kind;
   logic [7:0]  cap_op;
   logic [31:0] cap_value;

   expr_tokenizer #(.DATA_W(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_char      (in_char),
      .in_last      (in_last),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_kind     (out_kind),
      .out_op       (out_op),
      .out_value    (out_value),
      .err_overflow (err_overflow),
      .err_char     (err_char)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [1:0] k, input logic [7:0] o, input logic [31:0] v,
                       input logic eo, input logic ec);
      tok_t t;
      t.kind = k; t.op = o; t.value = v; t.eo = eo; t.ec = ec;
      exp_q.push_back(t);
   endtask

   // tokens are popped on the cycle they are handed downstream
   always @(negedge clk) begin
      tok_t t;
      #2;
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL spurious_token observed kind=%0d op=%0h value=%0h expected none",
                   out_kind, out_op, out_value);
         end else begin
            t = exp_q.pop_front();
            $display("token kind=%0d op=%0h value=%0h eo=%0b ec=%0b",
                     out_kind, out_op, out_value, err_overflow, err_char);
            check("tok_kind", 64'(out_kind), 64'(t.kind));
            check("tok_op", 64'(out_op), 64'(t.op));
            check("tok_value", 64'(out_value), 64'(t.value));
            if (t.kind == 2'd2) begin
               check("end_err_overflow", 64'(err_overflow), 64'(t.eo));
               check("end_err_char", 64'(err_char), 64'(t.ec));
            end
         end
      end
      if (rst_n && stall_mode && out_valid && !out_ready) begin
         check("no_accept_while_stalled", 64'(in_ready), 64'(0));
      end
   end

   // back-pressure generator: hold each token for three cycles when enabled
   always @(negedge clk) begin
      if (stall_mode) begin
         if (out_valid && hold_cnt < 3) begin
            if (hold_cnt == 0) begin
               cap_kind  = out_kind;
               cap_op    = out_op;
               cap_value = out_value;
            end else begin
               check("stall_kind_stable", 64'(out_kind), 64'(cap_kind));
               check("stall_op_stable", 64'(out_op), 64'(cap_op));
               check("stall_value_stable", 64'(out_value), 64'(cap_value));
            end
            out_ready = 1'b0;
            hold_cnt++;
         end else begin
            out_ready = 1'b1;
            hold_cnt  = 0;
         end
      end
   end

   task automatic send(input logic [7:0] c, input logic last);
      int n;
      @(negedge clk);
      in_valid = 1'b1;
      in_char  = c;
      in_last  = last;
      #1;
      n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 200) check("in_ready_timeout", 64'(in_ready), 64'(1));
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_char  = 8'h00;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) begin
         send(s[i], (i == s.len() - 1));
      end
      idle();
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      check(tag, 64'(exp_q.size()), 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_char   = 8'h00;
      in_last   = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out_kind", 64'(out_kind), 64'(0));
      check("rst_out_op", 64'(out_op), 64'(0));
      check("rst_out_value", 64'(out_value), 64'(0));
      check("rst_err_overflow", 64'(err_overflow), 64'(0));
      check("rst_err_char", 64'(err_char), 64'(0));
      check("rst_in_ready", 64'(in_ready), 64'(1));
      rst_n = 1'b1;

      // "12+3": input stalls exactly one cycle after '+'
      push(2'd0, 8'h00, 32'd12, 1'b0, 1'b0);
      push(2'd1, 8'h2B, 32'd0, 1'b0, 1'b0);
      push(2'd0, 8'h00, 32'd3, 1'b0, 1'b0);
      push(2'd2, 8'h00, 32'd0, 1'b0, 1'b0);
      send("1", 1'b0);
      send("2", 1'b0);
      send("+", 1'b0);
      idle();
      #1;
      check("flush_in_ready_low", 64'(in_ready), 64'(0));
      @(negedge clk);
      #1;
      check("flush_in_ready_back", 64'(in_ready), 64'(1));
      send("3", 1'b1);
      idle();
      drain("drain_12p3");

      // spaces separate literals and emit nothing themselves
      push(2'd0, 8'h00, 32'd5, 1'b0, 1'b0);
      push(2'd0, 8'h00, 32'd6, 1'b0, 1'b0);
      push(2'd1, 8'h2B, 32'd0, 1'b0, 1'b0);
      push(2'd0, 8'h00, 32'd20, 1'b0, 1'b0);
      push(2'd1, 8'h2B, 32'd0, 1'b0, 1'b0);
      push(2'd2, 8'h00, 32'd0, 1'b0, 1'b0);
      send_str("5 6 + 20 +");
      drain("drain_spaces");

      // 2^32 saturates and flags overflow; flags clear for the next expression
      push(2'd0, 8'h00, 32'hFFFF_FFFF, 1'b0, 1'b0);
      push(2'd2, 8'h00, 32'd0, 1'b1, 1'b0);
      send_str("4294967296");
      drain("drain_overflow");
      push(2'd0, 8'h00, 32'd7, 1'b0, 1'b0);
      push(2'd2, 8'h00, 32'd0, 1'b0, 1'b0);
      send_str("7");
      drain("drain_after_overflow");

      // illegal byte inside a literal is dropped
      push(2'd0, 8'h00, 32'd34, 1'b0, 1'b0);
      push(2'd2, 8'h00, 32'd0, 1'b0, 1'b1);
      send_str("3a4");
      drain("drain_badchar");

      // downstream back-pressure
      push(2'd0, 8'h00, 32'd8, 1'b0, 1'b0);
      push(2'd1, 8'h2A, 32'd0, 1'b0, 1'b0);
      push(2'd0, 8'h00, 32'd9, 1'b0, 1'b0);
      push(2'd2, 8'h00, 32'd0, 1'b0, 1'b0);
      stall_mode = 1'b1;
      send_str("8*9");
      drain("drain_stall");
      stall_mode = 1'b0;
      @(negedge clk);
      out_ready = 1'b1;

      // reset mid-literal discards the partial "45"
      send("4", 1'b0);
      send("5", 1'b0);
      idle();
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 64'(out_valid), 64'(0));
      check("midrst_in_ready", 64'(in_ready), 64'(1));
      @(negedge clk);
      rst_n = 1'b1;
      push(2'd0, 8'h00, 32'd6, 1'b0, 1'b0);
      push(2'd2, 8'h00, 32'd0, 1'b0, 1'b0);
      send_str("6");
      drain("drain_midrst");

`ifdef EXPR_TOKENIZER_PAREN_EN
      push(2'd1, 8'h28, 32'd0, 1'b0, 1'b0);
      push(2'd0, 8'h00, 32'd1, 1'b0, 1'b0);
      push(2'd1, 8'h29, 32'd0, 1'b0, 1'b0);
      push(2'd2, 8'h00, 32'd0, 1'b0, 1'b0);
`else
      push(2'd0, 8'h00, 32'd1, 1'b0, 1'b0);
      push(2'd2, 8'h00, 32'd0, 1'b0, 1'b1);
`endif
      send_str("(1)");
      drain("drain_paren");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
